// File: rtl/cond_pkg.sv
// Shared condition-code constants and NZCV bit positions for the E-stage
// flag unit and the decode-stage early-branch logic.
package cond_pkg;
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

   localparam logic [1:0] FLAGW_NZ  = 2'b10;
   localparam logic [1:0] FLAGW_CV  = 2'b01;
   localparam logic [1:0] FLAGW_ALL = 2'b11;
endpackage

// File: rtl/cond_check.sv
// Pure combinational ARM condition evaluation of a cond field against NZCV.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);
   logic n, z, c, v;

   always_comb begin
      n = flags[N_IDX];
      z = flags[Z_IDX];
      c = flags[C_IDX];
      v = flags[V_IDX];
      cond_ex = 1'b0;
      unique case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
         default: cond_ex = 1'b0;
      endcase
   end
endmodule

// File: rtl/cond_flag_unit.sv
// E-stage NZCV register with FlagW-masked update, cond-gated write enables,
// branch resolution against the predictor and saturating squash/mispredict counters.
module cond_flag_unit
   import cond_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ValidE,
   input  logic             StallE,
   input  logic             FlushE,
   input  logic [3:0]       CondE,
   input  logic [1:0]       FlagWE,
   input  logic [3:0]       ALUFlags,
   input  logic             PCSE,
   input  logic             RegWE,
   input  logic             MemWE,
   input  logic             BranchE,
   input  logic             PredTakenE,
   output logic [3:0]       Flags,
   output logic             CondExE,
   output logic             PCSrcE,
   output logic             RegWGE,
   output logic             MemWGE,
   output logic             BrTakenE,
   output logic             MispredictE,
   output logic [CNT_W-1:0] SquashCnt,
   output logic [CNT_W-1:0] MispredCnt
);
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
   logic             live, pass, squash;

   // Evaluated against the registered flags only; the setter's result lands at its own edge.
   cond_check u_cond_check (
      .cond    (CondE),
      .flags   (flags_q),
      .cond_ex (CondExE)
   );

   always_comb begin
      live        = ValidE & ~StallE & ~FlushE;
      pass        = live & CondExE;
      squash      = live & ~CondExE;
      PCSrcE      = PCSE & pass;
      RegWGE      = RegWE & pass;
      MemWGE      = MemWE & pass;
      BrTakenE    = BranchE & pass;
      MispredictE = live & BranchE & (BrTakenE != PredTakenE);

      flags_d = flags_q;
      if (pass && FlagWE[1]) begin
         flags_d[N_IDX] = ALUFlags[N_IDX];
         flags_d[Z_IDX] = ALUFlags[Z_IDX];
      end
      if (pass && FlagWE[0]) begin
         flags_d[C_IDX] = ALUFlags[C_IDX];
         flags_d[V_IDX] = ALUFlags[V_IDX];
      end

      squash_cnt_d  = squash_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (squash && !(&squash_cnt_q))
         squash_cnt_d = squash_cnt_q + 1'b1;
      if (MispredictE && !(&mispred_cnt_q))
         mispred_cnt_d = mispred_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q       <= '0;
         squash_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         flags_q       <= flags_d;
         squash_cnt_q  <= squash_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign Flags      = flags_q;
   assign SquashCnt  = squash_cnt_q;
   assign MispredCnt = mispred_cnt_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: expectations queued at drive time, popped at sample time.
module tb_cond_flag_unit;
   import cond_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ValidE, StallE, FlushE, PCSE, RegWE, MemWE, BranchE, PredTakenE;
   logic [3:0]  CondE, ALUFlags;
   logic [1:0]  FlagWE;
   logic [3:0]  Flags, Flags4;
   logic        CondExE, PCSrcE, RegWGE, MemWGE, BrTakenE, MispredictE;
   logic        CondExE4, PCSrcE4, RegWGE4, MemWGE4, BrTakenE4, MispredictE4;
   logic [15:0] SquashCnt, MispredCnt;
   logic [3:0]  SquashCnt4, MispredCnt4;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t sb[$];
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   cond_flag_unit dut (
      .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
      .CondE(CondE), .FlagWE(FlagWE), .ALUFlags(ALUFlags), .PCSE(PCSE), .RegWE(RegWE),
      .MemWE(MemWE), .BranchE(BranchE), .PredTakenE(PredTakenE), .Flags(Flags),
      .CondExE(CondExE), .PCSrcE(PCSrcE), .RegWGE(RegWGE), .MemWGE(MemWGE),
      .BrTakenE(BrTakenE), .MispredictE(MispredictE), .SquashCnt(SquashCnt),
      .MispredCnt(MispredCnt)
   );

   cond_flag_unit #(.CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
      .CondE(CondE), .FlagWE(FlagWE), .ALUFlags(ALUFlags), .PCSE(PCSE), .RegWE(RegWE),
      .MemWE(MemWE), .BranchE(BranchE), .PredTakenE(PredTakenE), .Flags(Flags4),
      .CondExE(CondExE4), .PCSrcE(PCSrcE4), .RegWGE(RegWGE4), .MemWGE(MemWGE4),
      .BrTakenE(BrTakenE4), .MispredictE(MispredictE4), .SquashCnt(SquashCnt4),
      .MispredCnt(MispredCnt4)
   );

   task automatic push(input string t, input logic [31:0] v);
      sb.push_back('{t, v});
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         failed++;
         $error("FAIL scoreboard_underflow observed=%0h", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
   endtask

   task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] c,
                        input logic [1:0] fw, input logic [3:0] alu, input logic pcs,
                        input logic rw, input logic mw, input logic br, input logic pt);
      @(negedge clk);
      ValidE = v; StallE = st; FlushE = fl; CondE = c; FlagWE = fw; ALUFlags = alu;
      PCSE = pcs; RegWE = rw; MemWE = mw; BranchE = br; PredTakenE = pt;
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      drive(1, 0, 0, COND_AL, FLAGW_ALL, f, 0, 0, 0, 0, 0);
      push("set_flags", {28'd0, f});
      @(posedge clk); #1;
      pop_chk({28'd0, Flags});
   endtask

   initial begin
      reset_n = 1'b0;
      ValidE = 0; StallE = 0; FlushE = 0; CondE = COND_EQ; FlagWE = 2'b00; ALUFlags = 4'h0;
      PCSE = 0; RegWE = 0; MemWE = 0; BranchE = 0; PredTakenE = 0;
      #12;
      push("rst_flags", 32'h0); push("rst_squash", 32'h0); push("rst_mispred", 32'h0);
      pop_chk({28'd0, Flags}); pop_chk({16'd0, SquashCnt}); pop_chk({16'd0, MispredCnt});
      @(negedge clk); reset_n = 1'b1;

      // masked write: N,Z only, then C,V only
      drive(1, 0, 0, COND_AL, FLAGW_NZ, 4'hF, 0, 1, 0, 0, 0);
      push("al_condex", 32'h1); push("al_regwg", 32'h1);
      pop_chk({31'd0, CondExE}); pop_chk({31'd0, RegWGE});
      push("mask_nz", 32'hC);
      @(posedge clk); #1; pop_chk({28'd0, Flags});
      drive(1, 0, 0, COND_AL, FLAGW_CV, 4'h3, 0, 0, 0, 0, 0);
      push("mask_cv", 32'hF);
      @(posedge clk); #1; pop_chk({28'd0, Flags});

      // squash: NE fails with Z set
      set_flags(4'h4);
      drive(1, 0, 0, COND_NE, FLAGW_ALL, 4'hF, 1, 1, 1, 0, 0);
      push("sq_condex", 32'h0); push("sq_regwg", 32'h0); push("sq_memwg", 32'h0);
      push("sq_pcsrc", 32'h0);
      pop_chk({31'd0, CondExE}); pop_chk({31'd0, RegWGE}); pop_chk({31'd0, MemWGE});
      pop_chk({31'd0, PCSrcE});
      push("sq_cnt", 32'h1); push("sq_flags_hold", 32'h4);
      @(posedge clk); #1; pop_chk({16'd0, SquashCnt}); pop_chk({28'd0, Flags});

      // stall then flush of the same failing instruction
      drive(1, 1, 0, COND_NE, FLAGW_ALL, 4'hF, 1, 1, 1, 0, 0);
      push("stall_cnt", 32'h1); push("stall_flags", 32'h4);
      @(posedge clk); #1; pop_chk({16'd0, SquashCnt}); pop_chk({28'd0, Flags});
      drive(1, 0, 1, COND_NE, FLAGW_ALL, 4'hF, 1, 1, 1, 0, 0);
      push("flush_cnt", 32'h1); push("flush_flags", 32'h4);
      @(posedge clk); #1; pop_chk({16'd0, SquashCnt}); pop_chk({28'd0, Flags});

      // branches with N,V set
      set_flags(4'h9);
      drive(1, 0, 0, COND_GE, 2'b00, 4'h0, 0, 0, 0, 1, 0);
      push("ge_brtaken", 32'h1); push("ge_mispred", 32'h1);
      pop_chk({31'd0, BrTakenE}); pop_chk({31'd0, MispredictE});
      push("ge_mpcnt", 32'h1);
      @(posedge clk); #1; pop_chk({16'd0, MispredCnt});
      drive(1, 0, 0, COND_LT, 2'b00, 4'h0, 0, 0, 0, 1, 0);
      push("lt_brtaken", 32'h0); push("lt_mispred", 32'h0);
      pop_chk({31'd0, BrTakenE}); pop_chk({31'd0, MispredictE});
      push("lt_mpcnt", 32'h1); push("lt_sqcnt", 32'h2);
      @(posedge clk); #1; pop_chk({16'd0, MispredCnt}); pop_chk({16'd0, SquashCnt});

      // async reset mid-stall with all flags set and nonzero counters
      set_flags(4'hF);
      drive(1, 1, 0, COND_EQ, FLAGW_ALL, 4'h0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      push("arst_flags", 32'h0); push("arst_sq", 32'h0); push("arst_mp", 32'h0);
      push("arst_eq", 32'h0);
      pop_chk({28'd0, Flags}); pop_chk({16'd0, SquashCnt}); pop_chk({16'd0, MispredCnt});
      pop_chk({31'd0, CondExE});
      CondE = COND_NE; #1;
      push("arst_ne", 32'h1);
      pop_chk({31'd0, CondExE});
      @(negedge clk);
      reset_n = 1'b1; StallE = 0; ValidE = 0;

      // saturation: EQ fails repeatedly with Z clear
      for (int i = 0; i < 17; i++)
         drive(1, 0, 0, COND_EQ, 2'b00, 4'h0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      push("sat4_17", 32'hF); push("cnt16_17", 32'd17);
      pop_chk({28'd0, SquashCnt4}); pop_chk({16'd0, SquashCnt});
      drive(1, 0, 0, COND_EQ, 2'b00, 4'h0, 0, 0, 0, 0, 0);
      push("sat4_hold", 32'hF); push("cnt16_18", 32'd18);
      @(posedge clk); #1;
      pop_chk({28'd0, SquashCnt4}); pop_chk({16'd0, SquashCnt});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
